// File: rtl/ps2_led_bank_if.sv
// rtl/ps2_led_bank_if.sv - scan-code input and LED output bundle for ps2_led_bank
//
// Purpose: groups the PS/2 decoded-byte stream, timer tick, clear and LED
// outputs of ps2_led_bank into one interface.
// Signals:
//   clk_300k          timer enable tick, one clk_2 cycle wide
//   code_new_updated  one-cycle strobe: check_code holds a new byte
//   check_code [7:0]  received scan-code byte
//   leds_clr          synchronous clear of all LEDs and channel state
//   led [N_CH]        registered LED drive
//   led_changed[N_CH] one-cycle pulse when the matching led bit changes
// Modports: master drives the byte stream and reads the LEDs, slave is the
// LED bank itself.

interface ps2_led_bank_if #(
  parameter int N_CH = 3
);
  logic            clk_300k;
  logic            code_new_updated;
  logic [7:0]      check_code;
  logic            leds_clr;
  logic [N_CH-1:0] led;
  logic [N_CH-1:0] led_changed;

  modport master (
    output clk_300k, code_new_updated, check_code, leds_clr,
    input  led, led_changed
  );

  modport slave (
    input  clk_300k, code_new_updated, check_code, leds_clr,
    output led, led_changed
  );
endinterface

// File: rtl/ps2_led_bank.sv
// rtl/ps2_led_bank.sv - multi-channel PS/2 lock-key LED controller
//
// Purpose: decodes F0/E0 prefixes from the PS/2 byte stream and runs one
// hold-off qualified FSM per channel that toggles (or, in momentary mode,
// follows) its LED when the configured key is held long enough.
// Ports:
//   clk_2   system clock, all state on the rising edge
//   rst_n   asynchronous active-low reset
//   bus     ps2_led_bank_if.slave: clk_300k, code_new_updated, check_code,
//           leds_clr in; led, led_changed out (both registered)

module ps2_led_bank #(
  parameter int                 N_CH           = 3,
  parameter logic [8*N_CH-1:0]  KEYCODES       = {8'h58, 8'h77, 8'h7E},
  parameter logic [N_CH-1:0]    EXT_MASK       = '0,
  parameter logic [N_CH-1:0]    MOMENTARY_MASK = '0,
  parameter int                 HOLDOFF        = 151,
  parameter int                 CNT_W          = 12
) (
  input  logic          clk_2,
  input  logic          rst_n,
  ps2_led_bank_if.slave bus
);

  localparam logic [7:0]       BRK_CODE = 8'hF0;
  localparam logic [7:0]       EXT_CODE = 8'hE0;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLDOFF);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_BRK = 2'd2
  } state_t;

  state_t           state [N_CH];
  logic [CNT_W-1:0] cnt   [N_CH];
  logic             brk_flag;
  logic             ext_flag;
  logic [N_CH-1:0]  led_q;
  logic [N_CH-1:0]  chg_q;

  logic             evt_valid;
  logic [N_CH-1:0]  make_match;
  logic [N_CH-1:0]  brk_match;

  assign bus.led         = led_q;
  assign bus.led_changed = chg_q;

  // A key event is any strobed byte that is not a prefix; it carries the
  // prefix flags accumulated since the previous event.
  always_comb begin
    evt_valid  = bus.code_new_updated &&
                 (bus.check_code != BRK_CODE) && (bus.check_code != EXT_CODE);
    make_match = '0;
    brk_match  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (evt_valid && (bus.check_code == KEYCODES[8*i +: 8]) &&
          (ext_flag == EXT_MASK[i])) begin
        make_match[i] = !brk_flag;
        brk_match[i]  = brk_flag;
      end
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      led_q    <= '0;
      chg_q    <= '0;
      brk_flag <= 1'b0;
      ext_flag <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      chg_q <= '0;
      if (bus.leds_clr) begin
        // Clear wins over any event in the same cycle; only LEDs that were
        // lit report a change.
        led_q    <= '0;
        chg_q    <= led_q;
        brk_flag <= 1'b0;
        ext_flag <= 1'b0;
        for (int i = 0; i < N_CH; i++) begin
          state[i] <= IDLE;
          cnt[i]   <= '0;
        end
      end else begin
        if (bus.code_new_updated) begin
          if (bus.check_code == BRK_CODE) begin
            brk_flag <= 1'b1;
          end else if (bus.check_code == EXT_CODE) begin
            ext_flag <= 1'b1;
          end else begin
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
          end
        end

        for (int i = 0; i < N_CH; i++) begin
          case (state[i])
            IDLE: begin
              if (make_match[i]) begin
                state[i] <= HOLD;
                cnt[i]   <= '0;
              end
            end
            HOLD: begin
              // A break beats a completed hold-off in the same cycle, so a
              // tap released right at the limit never acts.
              if (brk_match[i]) begin
                state[i] <= IDLE;
              end else if (cnt[i] >= HOLD_LIM) begin
                state[i] <= WAIT_BRK;
                if (MOMENTARY_MASK[i]) begin
                  led_q[i] <= 1'b1;
                  chg_q[i] <= ~led_q[i];
                end else begin
                  led_q[i] <= ~led_q[i];
                  chg_q[i] <= 1'b1;
                end
              end else if (bus.clk_300k) begin
                // Leaving HOLD at the limit keeps the count saturated.
                cnt[i] <= cnt[i] + CNT_W'(1);
              end
            end
            WAIT_BRK: begin
              if (brk_match[i]) begin
                state[i] <= IDLE;
                if (MOMENTARY_MASK[i]) begin
                  led_q[i] <= 1'b0;
                  chg_q[i] <= led_q[i];
                end
              end
            end
            default: state[i] <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_led_bank.sv
// tb/tb_ps2_led_bank.sv - self-checking bench for ps2_led_bank

module tb_ps2_led_bank;

  localparam int          N_CH = 3;
  localparam logic [23:0] KEYS = {8'h7E, 8'h14, 8'h58};
  localparam logic [2:0]  EXT  = 3'b010;
  localparam logic [2:0]  MOM  = 3'b001;
  localparam int          HOLD = 151;

  logic clk_2 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_2 = ~clk_2;

  ps2_led_bank_if #(.N_CH(N_CH)) bus();

  ps2_led_bank #(
    .N_CH(N_CH), .KEYCODES(KEYS), .EXT_MASK(EXT), .MOMENTARY_MASK(MOM),
    .HOLDOFF(HOLD), .CNT_W(12)
  ) dut (
    .clk_2(clk_2),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc_bad = 0;
  int obs_p [N_CH];
  int exp_p [N_CH];

  // Reference model: a key press is remembered as the global tick count at
  // which it was accepted; it acts once HOLD ticks have elapsed since then.
  longint     gt = 0;
  int         m_phase [N_CH];   // 0 released, 1 pressed/timing, 2 acted
  longint     m_t0    [N_CH];
  bit         m_brk, m_ext;
  logic [2:0] m_led, m_chg;

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) m_phase[i] = 0;
    m_brk = 0; m_ext = 0; m_led = '0; m_chg = '0;
  endtask

  task automatic model_edge(input bit stb, input logic [7:0] code, input bit clr, input bit t);
    bit ev, eb, ee, mk, bk, old;
    logic [7:0] kc;
    m_chg = '0;
    ev = 0; eb = 0; ee = 0;
    if (clr) begin
      m_chg = m_led;
      m_led = '0;
      for (int i = 0; i < N_CH; i++) m_phase[i] = 0;
      m_brk = 0; m_ext = 0;
    end else begin
      if (stb) begin
        if (code == 8'hF0) m_brk = 1;
        else if (code == 8'hE0) m_ext = 1;
        else begin ev = 1; eb = m_brk; ee = m_ext; m_brk = 0; m_ext = 0; end
      end
      for (int i = 0; i < N_CH; i++) begin
        kc  = KEYS[8*i +: 8];
        mk  = ev && !eb && code == kc && ee == EXT[i];
        bk  = ev &&  eb && code == kc && ee == EXT[i];
        old = m_led[i];
        if (m_phase[i] == 0) begin
          if (mk) begin m_phase[i] = 1; m_t0[i] = gt + longint'(t); end
        end else if (m_phase[i] == 1) begin
          if (bk) m_phase[i] = 0;
          else if (gt - m_t0[i] >= HOLD) begin
            m_phase[i] = 2;
            m_led[i] = MOM[i] ? 1'b1 : ~m_led[i];
          end
        end else begin
          if (bk) begin m_phase[i] = 0; if (MOM[i]) m_led[i] = 1'b0; end
        end
        m_chg[i] = old ^ m_led[i];
      end
    end
    for (int i = 0; i < N_CH; i++) exp_p[i] += int'(m_chg[i]);
    gt += longint'(t);
  endtask

  // One clock: drive at the negedge, sample 1 ns after the rising edge.
  // tk < 0 picks a random tick, otherwise forces it.
  task automatic step(input bit stb, input logic [7:0] code, input bit clr, input int tk);
    bit t;
    if (tk < 0) t = ($urandom_range(0, 2) == 0);
    else t = (tk != 0);
    bus.clk_300k = t; bus.code_new_updated = stb; bus.check_code = code; bus.leds_clr = clr;
    model_edge(stb, code, clr, t);
    @(posedge clk_2); #1;
    if (bus.led !== m_led || bus.led_changed !== m_chg) begin
      cyc_bad++;
      if (cyc_bad <= 5)
        $display("divergence at %0t: led=%b model=%b led_changed=%b model=%b",
                 $time, bus.led, m_led, bus.led_changed, m_chg);
    end
    for (int i = 0; i < N_CH; i++) obs_p[i] += int'(bus.led_changed[i]);
    bus.clk_300k = 0; bus.code_new_updated = 0; bus.check_code = 0; bus.leds_clr = 0;
    @(negedge clk_2);
  endtask

  task automatic key(input logic [7:0] c, input bit ext, input bit brk);
    if (ext) step(1, 8'hE0, 0, -1);
    if (brk) step(1, 8'hF0, 0, -1);
    step(1, c, 0, -1);
  endtask

  task automatic wait_ticks(input int n);
    longint target;
    int k;
    target = gt + n;
    k = 0;
    while (gt < target && k < 50 * n + 100) begin
      step(0, 8'h00, 0, -1);
      k++;
    end
    checks++;
    if (gt < target) begin
      errors++;
      $display("FAIL wait_ticks: got %0d ticks, required %0d", gt - (target - n), n);
    end
  endtask

  function automatic int sum_obs();
    int s = 0;
    for (int i = 0; i < N_CH; i++) s += obs_p[i];
    return s;
  endfunction

  task automatic test_reset();
    checks++;
    if (bus.led !== 3'b000) begin errors++; $display("FAIL reset_led: got %b expected 000", bus.led); end
    checks++;
    if (bus.led_changed !== 3'b000) begin errors++; $display("FAIL reset_changed: got %b expected 000", bus.led_changed); end
  endtask

  task automatic test_toggle();
    int p0;
    p0 = obs_p[2];
    step(1, 8'h7E, 0, 0);
    wait_ticks(HOLD);
    checks++;
    if (bus.led[2] !== 1'b0) begin errors++; $display("FAIL toggle_early: got %b expected 0", bus.led[2]); end
    step(0, 8'h00, 0, 0);
    checks++;
    if (bus.led !== 3'b100) begin errors++; $display("FAIL toggle_led: got %b expected 100", bus.led); end
    checks++;
    if (bus.led_changed !== 3'b100) begin errors++; $display("FAIL toggle_pulse: got %b expected 100", bus.led_changed); end
    key(8'h7E, 0, 1);
    repeat (5) step(0, 8'h00, 0, -1);
    checks++;
    if (obs_p[2] - p0 !== 1) begin errors++; $display("FAIL toggle_pulse_count: got %0d expected 1", obs_p[2] - p0); end
  endtask

  task automatic test_typematic();
    int p0;
    p0 = obs_p[2];
    step(1, 8'h7E, 0, -1);
    wait_ticks(HOLD + 5);
    repeat (3) key(8'h7E, 0, 0);
    wait_ticks(HOLD + 5);
    checks++;
    if (bus.led !== 3'b000) begin errors++; $display("FAIL typematic_led: got %b expected 000", bus.led); end
    checks++;
    if (obs_p[2] - p0 !== 1) begin errors++; $display("FAIL typematic_pulses: got %0d expected 1", obs_p[2] - p0); end
    key(8'h7E, 0, 1);
  endtask

  task automatic test_glitch();
    int s0;
    logic [2:0] l0;
    s0 = sum_obs(); l0 = bus.led;
    step(1, 8'h7E, 0, -1);
    wait_ticks(50);
    key(8'h7E, 0, 1);
    wait_ticks(HOLD + 20);
    checks++;
    if (bus.led !== l0) begin errors++; $display("FAIL glitch_led: got %b expected %b", bus.led, l0); end
    checks++;
    if (sum_obs() !== s0) begin errors++; $display("FAIL glitch_pulses: got %0d expected %0d", sum_obs(), s0); end
  endtask

  task automatic test_break_at_limit();
    logic [2:0] l0;
    l0 = bus.led;
    step(1, 8'h7E, 0, 0);
    wait_ticks(HOLD - 1);
    step(1, 8'hF0, 0, 0);
    step(1, 8'h7E, 0, 1);
    wait_ticks(HOLD + 10);
    checks++;
    if (bus.led !== l0) begin errors++; $display("FAIL break_at_limit: got %b expected %b", bus.led, l0); end
  endtask

  task automatic test_momentary();
    step(1, 8'h58, 0, -1);
    wait_ticks(HOLD);
    step(0, 8'h00, 0, 0);
    checks++;
    if (bus.led[0] !== 1'b1) begin errors++; $display("FAIL mom_on: got %b expected 1", bus.led[0]); end
    wait_ticks(49);
    step(1, 8'hF0, 0, 0);
    checks++;
    if (bus.led[0] !== 1'b1) begin errors++; $display("FAIL mom_held: got %b expected 1", bus.led[0]); end
    step(1, 8'h58, 0, 0);
    checks++;
    if (bus.led[0] !== 1'b0 || bus.led_changed[0] !== 1'b1) begin
      errors++; $display("FAIL mom_release: got led=%b chg=%b expected led=0 chg=1", bus.led[0], bus.led_changed[0]);
    end
  endtask

  task automatic test_ext();
    key(8'h14, 0, 0);
    wait_ticks(HOLD + 20);
    checks++;
    if (bus.led[1] !== 1'b0) begin errors++; $display("FAIL ext_plain: got %b expected 0", bus.led[1]); end
    key(8'h14, 0, 1);
    key(8'h14, 1, 0);
    wait_ticks(HOLD + 20);
    checks++;
    if (bus.led[1] !== 1'b1) begin errors++; $display("FAIL ext_toggle_on: got %b expected 1", bus.led[1]); end
    step(1, 8'hF0, 0, -1);
    step(1, 8'hE0, 0, -1);
    step(1, 8'h14, 0, -1);
    key(8'h14, 1, 0);
    wait_ticks(HOLD + 20);
    checks++;
    if (bus.led[1] !== 1'b0) begin errors++; $display("FAIL ext_toggle_off: got %b expected 0", bus.led[1]); end
    key(8'h14, 1, 1);
  endtask

  task automatic test_clr();
    key(8'h7E, 0, 0);
    wait_ticks(HOLD + 5);
    key(8'h7E, 0, 1);
    key(8'h58, 0, 0);
    wait_ticks(HOLD + 5);
    checks++;
    if (bus.led !== 3'b101) begin errors++; $display("FAIL clr_setup: got %b expected 101", bus.led); end
    step(1, 8'h7E, 1, -1);
    checks++;
    if (bus.led !== 3'b000 || bus.led_changed !== 3'b101) begin
      errors++; $display("FAIL clr_apply: got led=%b chg=%b expected led=000 chg=101", bus.led, bus.led_changed);
    end
    wait_ticks(HOLD + 20);
    checks++;
    if (bus.led !== 3'b000) begin errors++; $display("FAIL clr_no_hold: got %b expected 000", bus.led); end
  endtask

  task automatic test_async_reset();
    int s0;
    key(8'h7E, 0, 0);
    wait_ticks(HOLD + 5);
    key(8'h7E, 0, 1);
    step(1, 8'h7E, 0, -1);
    wait_ticks(50);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.led !== 3'b000 || bus.led_changed !== 3'b000) begin
      errors++; $display("FAIL async_reset: got led=%b chg=%b expected 000/000", bus.led, bus.led_changed);
    end
    @(negedge clk_2);
    @(negedge clk_2);
    rst_n = 1'b1;
    model_reset();
    s0 = sum_obs();
    wait_ticks(HOLD + 20);
    checks++;
    if (bus.led !== 3'b000 || sum_obs() !== s0) begin
      errors++; $display("FAIL after_reset: got led=%b pulses=%0d expected 000/%0d", bus.led, sum_obs() - s0, 0);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [7];
    logic [7:0] c;
    pool[0] = 8'h7E; pool[1] = 8'h14; pool[2] = 8'h58; pool[3] = 8'hF0;
    pool[4] = 8'hE0; pool[5] = 8'h77; pool[6] = 8'h00;
    for (int n = 0; n < 6000; n++) begin
      c = pool[$urandom_range(0, 6)];
      if (c == 8'h00) c = 8'($urandom_range(0, 255));
      step($urandom_range(0, 39) == 0, c, $urandom_range(0, 299) == 0, -1);
    end
    for (int i = 0; i < N_CH; i++) begin
      checks++;
      if (obs_p[i] !== exp_p[i]) begin errors++; $display("FAIL pulse_total ch%0d: got %0d expected %0d", i, obs_p[i], exp_p[i]); end
    end
    checks++;
    if (cyc_bad !== 0) begin errors++; $display("FAIL cycle_model: got %0d divergent cycles expected 0", cyc_bad); end
  endtask

  initial begin
    for (int i = 0; i < N_CH; i++) begin obs_p[i] = 0; exp_p[i] = 0; end
    model_reset();
    bus.clk_300k = 0; bus.code_new_updated = 0; bus.check_code = 0; bus.leds_clr = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_2);
    rst_n = 1'b1;
    test_reset();
    test_toggle();
    test_typematic();
    test_glitch();
    test_break_at_limit();
    test_momentary();
    test_ext();
    test_clr();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_led_bank.md
Name: ps2_led_bank

Overview:
Parametrised multi-channel PS/2 lock-key LED controller. Watches the decoded scan-code stream from the PS/2 receiver (code_new_updated strobe plus check_code byte) and drives one LED per channel. The defaults cover the Scroll, Num and Caps Lock keys. Each channel has its own hold-off qualification timer, break-code tracking, E0-prefix matching and a toggle or momentary mode. The block sits directly after the PS/2 byte receiver, on the same clk_2 domain, and uses the shared clk_300k enable as its timer tick.

Parameters:
N_CH, 3, number of LED channels (1..8)
KEYCODES, {8'h58,8'h77,8'h7E}, packed N_CH x 8 make codes; channel i = bits [8i+7:8i]
EXT_MASK, 3'b000, bit i=1: channel i matches only E0-prefixed codes; bit i=0: non-prefixed only
MOMENTARY_MASK, 3'b000, bit i=1: momentary mode; bit i=0: toggle mode
HOLDOFF, 151, clk_300k ticks a make must persist before the channel acts
CNT_W, 12, hold-off counter width; must satisfy HOLDOFF < 2**CNT_W

Ports:
clk_2  in  1  system clock; all state is on the rising edge
rst_n  in  1  asynchronous active-low reset
clk_300k  in  1  timer enable tick, one clk_2 cycle wide, synchronous to clk_2
code_new_updated  in  1  one-cycle strobe: check_code holds a new byte
check_code  in  8  received scan-code byte
leds_clr  in  1  synchronous clear: all LEDs off, all channels to IDLE
led  out  N_CH  LED drive, registered
led_changed  out  N_CH  one-cycle pulse when led[i] changes value

Behaviour:
- Reset (rst_n=0, asynchronous) sets: led=0, led_changed=0, all channel FSMs=IDLE, counters=0, brk_flag=0, ext_flag=0.
- Prefix decoder (shared, acts only on code_new_updated):
  - 8'hF0 sets brk_flag.
  - 8'hE0 sets ext_flag.
  - Any other byte is a key event: make if brk_flag=0, break if brk_flag=1, tagged with ext_flag. Both flags clear in the same cycle.
  - Prefixes accumulate in either order (E0 F0 xx and F0 E0 xx are equivalent).
- Channel i match: event code == KEYCODES[i] and ext tag == EXT_MASK[i]. The match is evaluated in the strobe cycle and acted on at the next clock edge.
- Per-channel FSM:
  - IDLE: on a make match, go to HOLD and clear the counter. All other events are ignored.
  - HOLD: the counter increments on each clk_300k tick and saturates at HOLDOFF. When counter >= HOLDOFF, go to WAIT_BRK on the next edge and:
    - toggle mode: invert led[i];
    - momentary mode: set led[i]=1.
  - HOLD, break match before hold-off completes: return to IDLE with no LED change (glitch rejection). Repeat makes in HOLD do not restart the counter.
  - WAIT_BRK: typematic repeat makes are ignored. On a break match, go to IDLE; in momentary mode also clear led[i].
  - Breaks for non-matching codes never affect a channel.
- Latency:
  - Toggle mode: a make accepted at edge T changes led at edge T + (cycles to the HOLDOFF-th tick) + 1.
  - Momentary release: led clears one edge after the matching break strobe.
- led_changed[i]: registered, high for exactly the one cycle after led[i] takes a new value. No pulse if the value does not change (e.g. leds_clr while already 0).
- leds_clr has priority over every event in the same cycle. It clears led, all FSMs, counters and both flags, and pulses led_changed for each channel whose LED was 1.
- Simultaneous clk_300k and code strobe: both are processed in the same cycle. A break that arrives in the same cycle the counter reaches HOLDOFF wins: the channel returns to IDLE with no toggle.
- Channels are fully independent. Several channels may be in HOLD at once, and each times its own hold-off.
- Unused bits: none. All state is one FSM per channel with its own counter.

Test Plan:
- Reset, then make 8'h7E; 151 ticks later break F0 7E -> led=3'b100, led_changed[2] pulses once, channel back in IDLE.
- Repeat the same sequence a second time -> led[2] returns to 0; typematic repeats 7E 7E 7E while in WAIT_BRK cause no extra toggle.
- Make 8'h77, then F0 77 after 50 ticks -> led unchanged, no led_changed pulse (glitch rejected).
- MOMENTARY_MASK=3'b001: make 58 held for 200 ticks -> led[0]=1 after tick 151; F0 58 -> led[0]=0 one edge later.
- EXT_MASK=3'b010, KEYCODES[1]=8'h14: plain 14 -> ignored; E0 14 held past hold-off -> led[1] toggles; release F0 E0 14 -> IDLE.
- led=3'b101, then leds_clr asserted in the same cycle as a 7E strobe -> led=0, led_changed=3'b101 for one cycle, no channel enters HOLD.
- Assert rst_n=0 mid-HOLD (async, between edges) -> led=0 immediately, FSMs IDLE, no pulse after release.
